// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
// Mode selectors plus a clog2 that never returns zero, so index buses stay at least one bit wide.
package prio_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/result handshake bundle for prio_encoder_rr; the mask field exists only with PRIO_ENC_MASK_EN.
// slave = the encoder, master = whoever issues requests and consumes results.
interface prio_encoder_rr_if
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int POS_W = clog2_min1(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] req;
`ifdef PRIO_ENC_MASK_EN
    logic [WIDTH-1:0] mask;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [POS_W-1:0] pos;
    logic [WIDTH-1:0] onehot;
    logic             none;

    modport slave (
        input  in_valid, req,
`ifdef PRIO_ENC_MASK_EN
        input  mask,
`endif
        input  out_ready,
        output in_ready, out_valid, pos, onehot, none
    );

    modport master (
        output in_valid, req,
`ifdef PRIO_ENC_MASK_EN
        output mask,
`endif
        output out_ready,
        input  in_ready, out_valid, pos, onehot, none
    );
endinterface

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit encoder: index, isolated one-hot and an any flag.
// Purely combinational, no latency; no handshake so no backpressure.
// Index 0 is reported when nothing is set; callers must qualify with any.
module prio_enc_lsb
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int POS_W = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [POS_W-1:0] idx,
    output logic [WIDTH-1:0] oh,
    output logic             any
);

    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) idx = POS_W'(i);
        end
    end

    // Two's complement trick isolates the lowest set bit.
    assign oh  = req & (~req + WIDTH'(1));
    assign any = |req;

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder, fixed (bit 0 first) or round-robin; PRIO_ENC_MASK_EN adds a request mask.
// Latency 1 cycle, throughput 1 result per cycle.
// Backpressure: result held while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_FIXED,
    parameter int POS_W = clog2_min1(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    prio_encoder_rr_if.slave    bus
);

    logic [WIDTH-1:0]   eff;
    logic [2*WIDTH-1:0] rot_dbl;
    logic [WIDTH-1:0]   rot;
    logic [POS_W-1:0]   lsb_idx;
    logic [WIDTH-1:0]   lsb_oh;
    logic               lsb_any;
    logic [2*WIDTH-1:0] oh_dbl;
    logic [POS_W:0]     sum;
    logic [POS_W:0]     sum_mod;
    logic [POS_W-1:0]   pos_new;
    logic [WIDTH-1:0]   onehot_new;
    logic [POS_W-1:0]   ptr_q;
    logic [POS_W-1:0]   ptr_next;
    logic               accept;

`ifdef PRIO_ENC_MASK_EN
    assign eff = bus.req & ~bus.mask;
`else
    assign eff = bus.req;
`endif

    // Rotate right by ptr so the search always starts at bit 0 of the encoder.
    assign rot_dbl = {eff, eff} >> ptr_q;
    assign rot     = rot_dbl[WIDTH-1:0];

    prio_enc_lsb #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_lsb (
        .req (rot),
        .idx (lsb_idx),
        .oh  (lsb_oh),
        .any (lsb_any)
    );

    // Undo the rotation; the extra bit keeps idx+ptr from overflowing before the wrap.
    always_comb begin
        sum     = {1'b0, lsb_idx} + {1'b0, ptr_q};
        sum_mod = sum;
        if (sum >= (POS_W+1)'(WIDTH)) sum_mod = sum - (POS_W+1)'(WIDTH);
    end

    assign oh_dbl     = {lsb_oh, lsb_oh} << ptr_q;
    assign pos_new    = lsb_any ? sum_mod[POS_W-1:0] : '0;
    assign onehot_new = lsb_any ? oh_dbl[2*WIDTH-1:WIDTH] : '0;
    assign ptr_next   = (pos_new == POS_W'(WIDTH - 1)) ? '0 : pos_new + POS_W'(1);

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.pos       <= '0;
            bus.onehot    <= '0;
            bus.none      <= 1'b0;
            ptr_q         <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.pos       <= pos_new;
            bus.onehot    <= onehot_new;
            bus.none      <= !lsb_any;
            if (MODE == MODE_RR && lsb_any) ptr_q <= ptr_next;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench: fixed W=8, round-robin W=8 and round-robin W=5 encoders side by side.
module tb_prio_encoder_rr;
    import prio_enc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    prio_encoder_rr_if #(.WIDTH(8)) f_if ();
    prio_encoder_rr_if #(.WIDTH(8)) r_if ();
    prio_encoder_rr_if #(.WIDTH(5)) q_if ();

    prio_encoder_rr #(.WIDTH(8), .MODE(MODE_FIXED)) u_fix (.clk(clk), .reset(reset), .bus(f_if));
    prio_encoder_rr #(.WIDTH(8), .MODE(MODE_RR))    u_rr  (.clk(clk), .reset(reset), .bus(r_if));
    prio_encoder_rr #(.WIDTH(5), .MODE(MODE_RR))    u_rr5 (.clk(clk), .reset(reset), .bus(q_if));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        f_if.in_valid = 1'b1; f_if.req = 8'hFF; f_if.out_ready = 1'b0;
        r_if.in_valid = 1'b1; r_if.req = 8'hFF; r_if.out_ready = 1'b0;
        q_if.in_valid = 1'b1; q_if.req = 5'h1F; q_if.out_ready = 1'b0;
`ifdef PRIO_ENC_MASK_EN
        f_if.mask = '0; r_if.mask = '0; q_if.mask = '0;
`endif
        tick();
        tick();
        reset = 1'b0;
        f_if.in_valid = 1'b0; r_if.in_valid = 1'b0; q_if.in_valid = 1'b0;
        #1;
        tests++; if (f_if.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", f_if.out_valid); end
        tests++; if (f_if.pos !== 3'd0) begin fails++; $display("FAIL reset_pos: got %0d expected 0", f_if.pos); end
        tests++; if (f_if.onehot !== 8'h00) begin fails++; $display("FAIL reset_onehot: got %h expected 00", f_if.onehot); end
        tests++; if (f_if.none !== 1'b0) begin fails++; $display("FAIL reset_none: got %b expected 0", f_if.none); end
        tests++; if (f_if.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", f_if.in_ready); end
        tests++; if (r_if.out_valid !== 1'b0 || q_if.out_valid !== 1'b0) begin fails++; $display("FAIL reset_rr_out_valid: got %b/%b expected 0/0", r_if.out_valid, q_if.out_valid); end
    endtask

    task automatic test_fixed();
        f_if.out_ready = 1'b1;
        f_if.in_valid = 1'b1; f_if.req = 8'b1010_1000;
        tick();
        tests++; if (f_if.out_valid !== 1'b1) begin fails++; $display("FAIL fix_a8_valid: got %b expected 1", f_if.out_valid); end
        tests++; if (f_if.pos !== 3'd3) begin fails++; $display("FAIL fix_a8_pos: got %0d expected 3", f_if.pos); end
        tests++; if (f_if.onehot !== 8'h08) begin fails++; $display("FAIL fix_a8_onehot: got %h expected 08", f_if.onehot); end
        f_if.req = 8'h80;
        tick();
        tests++; if (f_if.pos !== 3'd7 || f_if.onehot !== 8'h80) begin fails++; $display("FAIL fix_80: got pos %0d oh %h expected 7 80", f_if.pos, f_if.onehot); end
        f_if.req = 8'h00;
        tick();
        tests++; if (f_if.none !== 1'b1 || f_if.out_valid !== 1'b1) begin fails++; $display("FAIL fix_zero_none: got none %b valid %b expected 1 1", f_if.none, f_if.out_valid); end
        tests++; if (f_if.pos !== 3'd0 || f_if.onehot !== 8'h00) begin fails++; $display("FAIL fix_zero_pos: got pos %0d oh %h expected 0 00", f_if.pos, f_if.onehot); end
        f_if.in_valid = 1'b0;
        tick();
        tests++; if (f_if.out_valid !== 1'b0) begin fails++; $display("FAIL fix_drain: got %b expected 0", f_if.out_valid); end
    endtask

    task automatic test_rr_back_to_back();
        logic [2:0] exp_pos [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        r_if.out_ready = 1'b1;
        r_if.in_valid = 1'b1; r_if.req = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (r_if.pos !== exp_pos[i] || r_if.out_valid !== 1'b1) begin fails++; $display("FAIL rr_ff_%0d: got pos %0d valid %b expected %0d 1", i, r_if.pos, r_if.out_valid, exp_pos[i]); end
        end
        r_if.req = 8'h01;
        tick();
        tests++; if (r_if.pos !== 3'd0 || r_if.onehot !== 8'h01) begin fails++; $display("FAIL rr_wrap_search: got pos %0d oh %h expected 0 01", r_if.pos, r_if.onehot); end
        r_if.req = 8'hFF;
        tick();
        tests++; if (r_if.pos !== 3'd1) begin fails++; $display("FAIL rr_ptr_after_wrap: got %0d expected 1", r_if.pos); end
        r_if.req = 8'h00;
        tick();
        tests++; if (r_if.none !== 1'b1 || r_if.onehot !== 8'h00) begin fails++; $display("FAIL rr_zero: got none %b oh %h expected 1 00", r_if.none, r_if.onehot); end
        r_if.req = 8'hFF;
        tick();
        tests++; if (r_if.pos !== 3'd2 || r_if.none !== 1'b0) begin fails++; $display("FAIL rr_ptr_hold_on_zero: got pos %0d none %b expected 2 0", r_if.pos, r_if.none); end
        r_if.req = 8'h02;
        tick();
        tests++; if (r_if.pos !== 3'd1 || r_if.onehot !== 8'h02) begin fails++; $display("FAIL rr_single_bit: got pos %0d oh %h expected 1 02", r_if.pos, r_if.onehot); end
        r_if.req = 8'b0101_0001;
        tick();
        tests++; if (r_if.pos !== 3'd4 || r_if.onehot !== 8'h10) begin fails++; $display("FAIL rr_mid_search: got pos %0d oh %h expected 4 10", r_if.pos, r_if.onehot); end
        r_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_rr_width5();
        q_if.out_ready = 1'b1;
        q_if.in_valid = 1'b1; q_if.req = 5'b10000;
        tick();
        tests++; if (q_if.pos !== 3'd4 || q_if.onehot !== 5'b10000) begin fails++; $display("FAIL rr5_top: got pos %0d oh %b expected 4 10000", q_if.pos, q_if.onehot); end
        q_if.req = 5'b11111;
        tick();
        tests++; if (q_if.pos !== 3'd0 || q_if.onehot !== 5'b00001) begin fails++; $display("FAIL rr5_wrap: got pos %0d oh %b expected 0 00001", q_if.pos, q_if.onehot); end
        q_if.req = 5'b00001;
        tick();
        tests++; if (q_if.pos !== 3'd0) begin fails++; $display("FAIL rr5_wrap_search: got pos %0d expected 0", q_if.pos); end
        q_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        f_if.out_ready = 1'b0;
        f_if.in_valid = 1'b1; f_if.req = 8'h04;
        tick();
        tests++; if (f_if.pos !== 3'd2 || f_if.out_valid !== 1'b1) begin fails++; $display("FAIL bp_first: got pos %0d valid %b expected 2 1", f_if.pos, f_if.out_valid); end
        f_if.req = 8'h40;
        for (int i = 0; i < 3; i++) begin
            tests++; if (f_if.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_%0d: got %b expected 0", i, f_if.in_ready); end
            tick();
            tests++; if (f_if.pos !== 3'd2 || f_if.out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_%0d: got pos %0d valid %b expected 2 1", i, f_if.pos, f_if.out_valid); end
        end
        f_if.out_ready = 1'b1;
        #1;
        tests++; if (f_if.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", f_if.in_ready); end
        tick();
        tests++; if (f_if.pos !== 3'd6 || f_if.out_valid !== 1'b1 || f_if.onehot !== 8'h40) begin fails++; $display("FAIL bp_consume_accept: got pos %0d valid %b oh %h expected 6 1 40", f_if.pos, f_if.out_valid, f_if.onehot); end
        f_if.in_valid = 1'b0;
        tick();
        tests++; if (f_if.out_valid !== 1'b0 || f_if.pos !== 3'd6) begin fails++; $display("FAIL bp_drain: got valid %b pos %0d expected 0 6", f_if.out_valid, f_if.pos); end
    endtask

    task automatic test_reset_mid();
        f_if.out_ready = 1'b0;
        f_if.in_valid = 1'b1; f_if.req = 8'h20;
        tick();
        r_if.out_ready = 1'b1;
        r_if.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        f_if.in_valid = 1'b0;
        #1;
        tests++; if (f_if.out_valid !== 1'b0 || f_if.pos !== 3'd0) begin fails++; $display("FAIL reset_mid: got valid %b pos %0d expected 0 0", f_if.out_valid, f_if.pos); end
        r_if.in_valid = 1'b1; r_if.req = 8'hFF;
        tick();
        tests++; if (r_if.pos !== 3'd0) begin fails++; $display("FAIL reset_ptr: got pos %0d expected 0", r_if.pos); end
        r_if.in_valid = 1'b0;
        tick();
    endtask

`ifdef PRIO_ENC_MASK_EN
    task automatic test_mask();
        f_if.out_ready = 1'b1;
        f_if.in_valid = 1'b1; f_if.req = 8'h0F; f_if.mask = 8'h07;
        tick();
        tests++; if (f_if.pos !== 3'd3 || f_if.none !== 1'b0) begin fails++; $display("FAIL mask_partial: got pos %0d none %b expected 3 0", f_if.pos, f_if.none); end
        f_if.req = 8'h03; f_if.mask = 8'h03;
        tick();
        tests++; if (f_if.none !== 1'b1 || f_if.onehot !== 8'h00) begin fails++; $display("FAIL mask_full: got none %b oh %h expected 1 00", f_if.none, f_if.onehot); end
        f_if.in_valid = 1'b0; f_if.mask = 8'h00;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_rr_back_to_back();
        test_rr_width5();
        test_backpressure();
        test_reset_mid();
`ifdef PRIO_ENC_MASK_EN
        test_mask();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
